// File: rtl/video_pkg.sv
// Shared display-path definitions: default 640x480@60 timing, sync polarity and RGB332 channel expansion.
package video_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic {
    POL_LOW  = 1'b0,
    POL_HIGH = 1'b1
  } sync_pol_e;

  // Left-justified bit replication of a 3-bit (or 2-bit) field to 10 bits; callers keep the top bits they need.
  function automatic logic [9:0] rgb_field_expand(input logic [2:0] field, input logic two_bit);
    logic [11:0] rep3;
    rep3 = {4{field}};
    return two_bit ? {5{field[1:0]}} : rep3[11:2];
  endfunction

endpackage

// File: rtl/video_timing_gen_delay_line.sv
// Width/depth-parametrised shift register; every stage resets to RESET_VAL.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with frame-boundary run/stop control and delayed sync/DE/RGB output stage.
//   state        | meaning
//   ST_IDLE      | counters parked at (0,0), all outputs inactive
//   ST_RUN       | scanning, enable held high
//   ST_STOPPING  | enable dropped; finish current frame, then idle
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int PIXEL_DELAY = 8,
  parameter int OUT_BITS    = 8,
  parameter int COUNT_BITS  = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            color,
  output logic                  pixel_req,
  output logic [COUNT_BITS-1:0] count_h,
  output logic [COUNT_BITS-1:0] count_v,
  output logic                  line_start,
  output logic                  frame_start,
  output logic [15:0]           frame_count,
  output logic                  running,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vga_de,
  output logic [OUT_BITS-1:0]   vga_r,
  output logic [OUT_BITS-1:0]   vga_g,
  output logic [OUT_BITS-1:0]   vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [COUNT_BITS-1:0] H_LAST   = COUNT_BITS'(H_TOTAL - 1);
  localparam logic [COUNT_BITS-1:0] V_LAST   = COUNT_BITS'(V_TOTAL - 1);
  localparam logic [COUNT_BITS-1:0] H_VIS    = COUNT_BITS'(H_ACTIVE);
  localparam logic [COUNT_BITS-1:0] V_VIS    = COUNT_BITS'(V_ACTIVE);
  localparam logic [COUNT_BITS-1:0] HS_START = COUNT_BITS'(H_ACTIVE + H_FP);
  localparam logic [COUNT_BITS-1:0] HS_END   = COUNT_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [COUNT_BITS-1:0] VS_START = COUNT_BITS'(V_ACTIVE + V_FP);
  localparam logic [COUNT_BITS-1:0] VS_END   = COUNT_BITS'(V_ACTIVE + V_FP + V_SYNC);

  localparam sync_pol_e HS_ON = (HS_POL != 0) ? POL_HIGH : POL_LOW;
  localparam sync_pol_e VS_ON = (VS_POL != 0) ? POL_HIGH : POL_LOW;
  localparam logic      HS_ON_L = logic'(HS_ON);
  localparam logic      VS_ON_L = logic'(VS_ON);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  logic [1:0]            state, state_nxt;
  logic [COUNT_BITS-1:0] h, v, h_nxt, v_nxt;
  logic                  h_last, frame_last;
  logic                  hs_act, vs_act;
  logic [2:0]            sync_raw, sync_dly;
  logic [7:0]            color_q;

  assign h_last     = (h == H_LAST);
  assign frame_last = h_last && (v == V_LAST);

  always_comb begin
    state_nxt = state;
    h_nxt     = h;
    v_nxt     = v;
    if (state != ST_IDLE) begin
      h_nxt = h_last ? '0 : h + 1'b1;
      if (h_last) v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
    end
    case (state)
      ST_IDLE:     if (enable) state_nxt = ST_RUN;
      ST_RUN:      if (!enable) state_nxt = ST_STOPPING;
      // enable returning on the very last pixel keeps us running into the next frame
      ST_STOPPING: begin
        if (enable)          state_nxt = ST_RUN;
        else if (frame_last) state_nxt = ST_IDLE;
      end
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      state <= state_nxt;
      h     <= h_nxt;
      v     <= v_nxt;
    end
  end

  assign running     = (state != ST_IDLE);
  assign count_h     = h;
  assign count_v     = v;
  assign pixel_req   = running && (h < H_VIS) && (v < V_VIS);
  assign line_start  = running && (h == '0) && (v < V_VIS);
  assign frame_start = running && (h == '0) && (v == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            frame_count <= '0;
    else if (frame_start) frame_count <= frame_count + 16'd1;
  end

  assign hs_act   = running && (h >= HS_START) && (h < HS_END);
  assign vs_act   = running && (v >= VS_START) && (v < VS_END);
  assign sync_raw = {hs_act ? HS_ON_L : ~HS_ON_L, vs_act ? VS_ON_L : ~VS_ON_L, pixel_req};

  delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIXEL_DELAY),
    .RESET_VAL({~HS_ON_L, ~VS_ON_L, 1'b0})
  ) u_sync_dly (
    .clk  (clk),
    .reset(reset),
    .din  (sync_raw),
    .dout (sync_dly)
  );

  assign vga_hs = sync_dly[2];
  assign vga_vs = sync_dly[1];
  assign vga_de = sync_dly[0];

  // colour arrives one cycle before its DE slot, so a single register lines it up
  always_ff @(posedge clk or posedge reset) begin
    if (reset) color_q <= '0;
    else       color_q <= color;
  end

  assign vga_r = vga_de ? OUT_BITS'(rgb_field_expand(color_q[7:5], 1'b0) >> (10 - OUT_BITS)) : '0;
  assign vga_g = vga_de ? OUT_BITS'(rgb_field_expand(color_q[4:2], 1'b0) >> (10 - OUT_BITS)) : '0;
  assign vga_b = vga_de ? OUT_BITS'(rgb_field_expand({1'b0, color_q[1:0]}, 1'b1) >> (10 - OUT_BITS)) : '0;

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomised bench for video_timing_gen: two small-timing instances checked against a frame-position model.
module tb_video_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FT = HT * VT;
  localparam int DA = 5, NA = 8;
  localparam int DB = 1, NB = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic [7:0] color = 8'h00;

  logic        a_pix, a_ls, a_fs, a_run, a_hs, a_vs, a_de;
  logic [11:0] a_h, a_v;
  logic [15:0] a_fc;
  logic [NA-1:0] a_r, a_g, a_b;
  logic        b_pix, b_ls, b_fs, b_run, b_hs, b_vs, b_de;
  logic [11:0] b_h, b_v;
  logic [15:0] b_fc;
  logic [NB-1:0] b_r, b_g, b_b;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .PIXEL_DELAY(DA), .OUT_BITS(NA), .COUNT_BITS(12)
  ) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .color(color),
    .pixel_req(a_pix), .count_h(a_h), .count_v(a_v), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc), .running(a_run),
    .vga_hs(a_hs), .vga_vs(a_vs), .vga_de(a_de), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b)
  );

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .PIXEL_DELAY(DB), .OUT_BITS(NB), .COUNT_BITS(12)
  ) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .color(color),
    .pixel_req(b_pix), .count_h(b_h), .count_v(b_v), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc), .running(b_run),
    .vga_hs(b_hs), .vga_vs(b_vs), .vga_de(b_de), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b)
  );

  // Reference model: running flag, stop-pending flag and a linear position within the frame.
  bit   m_run = 0, m_pend = 0;
  int   m_p = 0, m_fc = 0;
  int   m_col = 0;
  bit   de_hist [64];
  bit   hs_hist [64];
  bit   vs_hist [64];

  function automatic bit m_pix_now();
    return m_run && (m_p % HT) < HA && (m_p / HT) < VA;
  endfunction
  function automatic bit m_hs_now();
    return m_run && (m_p % HT) >= HA + HF && (m_p % HT) < HA + HF + HSW;
  endfunction
  function automatic bit m_vs_now();
    return m_run && (m_p / HT) >= VA + VF && (m_p / HT) < VA + VF + VSW;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run = 0; m_pend = 0; m_p = 0; m_fc = 0; m_col = 0;
      for (int i = 0; i < 64; i++) begin
        de_hist[i] = 0; hs_hist[i] = 0; vs_hist[i] = 0;
      end
    end else begin
      for (int i = 63; i > 0; i--) begin
        de_hist[i] = de_hist[i-1]; hs_hist[i] = hs_hist[i-1]; vs_hist[i] = vs_hist[i-1];
      end
      de_hist[0] = m_pix_now(); hs_hist[0] = m_hs_now(); vs_hist[0] = m_vs_now();
      m_col = int'(color);
      if (m_run && m_p == 0) m_fc = (m_fc + 1) % 65536;
      if (!m_run) begin
        if (enable) begin m_run = 1; m_pend = 0; m_p = 0; end
      end else begin
        bit last;
        last = (m_p == FT - 1);
        m_p  = last ? 0 : m_p + 1;
        if (m_pend && last && !enable) begin
          m_run = 0; m_pend = 0;
        end else begin
          m_pend = !enable;
        end
      end
    end
  end

  function automatic int expand(input int field, input int k, input int n);
    int val;
    val = 0;
    for (int i = 0; i < n; i++) val = val * 2 + ((field >> (k - 1 - (i % k))) & 1);
    return val;
  endfunction

  int n_tests = 0, n_fail = 0, cyc = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic compare_all();
    int h, v;
    bit ls, fs;
    h  = m_p % HT;
    v  = m_p / HT;
    ls = m_run && h == 0 && v < VA;
    fs = m_run && m_p == 0;
    check("a_count_h", int'(a_h), h);
    check("a_count_v", int'(a_v), v);
    check("a_pixel_req", int'(a_pix), int'(m_pix_now()));
    check("a_line_start", int'(a_ls), int'(ls));
    check("a_frame_start", int'(a_fs), int'(fs));
    check("a_running", int'(a_run), int'(m_run));
    check("a_frame_count", int'(a_fc), m_fc);
    check("a_vga_hs", int'(a_hs), int'(!hs_hist[DA-1]));
    check("a_vga_vs", int'(a_vs), int'(!vs_hist[DA-1]));
    check("a_vga_de", int'(a_de), int'(de_hist[DA-1]));
    check("a_vga_r", int'(a_r), de_hist[DA-1] ? expand((m_col >> 5) & 7, 3, NA) : 0);
    check("a_vga_g", int'(a_g), de_hist[DA-1] ? expand((m_col >> 2) & 7, 3, NA) : 0);
    check("a_vga_b", int'(a_b), de_hist[DA-1] ? expand(m_col & 3, 2, NA) : 0);
    check("b_count_h", int'(b_h), h);
    check("b_count_v", int'(b_v), v);
    check("b_pixel_req", int'(b_pix), int'(m_pix_now()));
    check("b_frame_start", int'(b_fs), int'(fs));
    check("b_frame_count", int'(b_fc), m_fc);
    check("b_vga_hs", int'(b_hs), int'(hs_hist[DB-1]));
    check("b_vga_vs", int'(b_vs), int'(vs_hist[DB-1]));
    check("b_vga_de", int'(b_de), int'(de_hist[DB-1]));
    check("b_vga_r", int'(b_r), de_hist[DB-1] ? expand((m_col >> 5) & 7, 3, NB) : 0);
    check("b_vga_g", int'(b_g), de_hist[DB-1] ? expand((m_col >> 2) & 7, 3, NB) : 0);
    check("b_vga_b", int'(b_b), de_hist[DB-1] ? expand(m_col & 3, 2, NB) : 0);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic wait_pos(input string tag, input int hh, input int vv, input int fc_req);
    for (int i = 0; i < 2000; i++) begin
      step();
      if (a_run && int'(a_h) == hh && int'(a_v) == vv && (fc_req < 0 || int'(a_fc) == fc_req)) return;
    end
    check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_fs(input string tag, output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (a_fs) begin at = cyc; return; end
    end
    check({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int t0, t1, idle_cycles;

    // reset values
    repeat (3) step();
    check("rst_a_hs_inactive", int'(a_hs), 1);
    check("rst_b_hs_inactive", int'(b_hs), 0);
    check("rst_b_vs_inactive", int'(b_vs), 0);
    check("rst_frame_count", int'(a_fc), 0);
    reset = 1'b0;
    repeat (3) step();
    check("no_enable_idle", int'(a_run), 0);

    // start: frame_start one cycle after enable
    enable = 1'b1;
    step();
    check("start_fs", int'(a_fs), 1);
    check("start_pix", int'(a_pix), 1);
    repeat (2 * FT) begin
      step();
      color = 8'($urandom);
    end

    // full-scale colour on R and B
    color = 8'hE3;
    repeat (FT) begin
      step();
      if (a_de) begin
        check("e3_r", int'(a_r), 8'hFF);
        check("e3_g", int'(a_g), 8'h00);
        check("e3_b", int'(a_b), 8'hFF);
      end else begin
        check("rgb_blank", int'({a_r, a_g, a_b}), 0);
      end
    end

    // stop at (3,1) finishes the frame
    reset = 1'b1; step(); reset = 1'b0; step();
    step();
    wait_pos("stop", 3, 1, -1);
    enable = 1'b0;
    idle_cycles = 0;
    while (a_run && idle_cycles < 300) begin
      step();
      idle_cycles++;
    end
    check("stop_cycles", idle_cycles, FT - (1 * HT + 3));
    check("stop_frame_count", int'(a_fc), 1);
    check("stop_count_h", int'(a_h), 0);

    // drop and re-raise enable mid-frame: frame period unchanged
    enable = 1'b1;
    wait_fs("restart", t0);
    wait_pos("drop", 3, 1, -1);
    enable = 1'b0;
    wait_pos("reraise", 5, 2, -1);
    enable = 1'b1;
    wait_fs("period", t1);
    check("frame_period", t1 - t0, FT);

    // enable drops on last pixel, then returns on last pixel of the stopping frame
    wait_pos("last_run", HT - 1, VT - 1, -1);
    enable = 1'b0;
    step();
    check("last_drop_running", int'(a_run), 1);
    wait_pos("last_stop", HT - 1, VT - 1, -1);
    enable = 1'b1;
    step();
    check("seam_running", int'(a_run), 1);
    check("seam_fs", int'(a_fs), 1);

    // asynchronous reset at (6,3) of frame 5
    reset = 1'b1; step(); reset = 1'b0;
    wait_pos("frame5", 6, 3, 5);
    reset = 1'b1;
    #1;
    compare_all();
    check("arst_running", int'(a_run), 0);
    check("arst_frame_count", int'(a_fc), 0);
    check("arst_a_hs", int'(a_hs), 1);
    check("arst_de", int'(a_de), 0);
    enable = 1'b0;
    step();
    reset = 1'b0;
    repeat (5) step();
    check("arst_stays_idle", int'(a_run), 0);
    enable = 1'b1;
    step();
    check("arst_restart_fs", int'(a_fs), 1);

    // randomised run/stop and colour
    for (int i = 0; i < 4000; i++) begin
      step();
      color = 8'($urandom);
      if ($urandom_range(0, 99) < 3) enable = ~enable;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
